// File: rtl/simon_seq_ctrl.sv
// Sequence controller for a Simon-style memory game: it owns the seed, the
// sequence length and the replay walk, and steers an external LFSR that produces the colors.
module simon_seq_ctrl #(
    parameter int MAX_LEN         = 32,
    parameter int STEPS_PER_COLOR = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed_in,
    input  logic        extend,
    input  logic        replay,
    input  logic        next,
    input  logic        abort,
    input  logic [31:0] lfsr_value,
    output logic        lfsr_enable,
    output logic        lfsr_load,
    output logic [31:0] lfsr_load_value,
    output logic [1:0]  color,
    output logic        color_valid,
    output logic        last,
    output logic        done,
    output logic [7:0]  level,
    output logic        full,
    output logic        busy
);

    localparam logic [1:0]  IDLE         = 2'd0;
    localparam logic [1:0]  LOAD         = 2'd1;
    localparam logic [1:0]  PRESENT      = 2'd2;
    localparam logic [1:0]  STEP         = 2'd3;
    localparam logic [31:0] DEFAULT_SEED = 32'h2048FAFA;
    localparam logic [7:0]  MAX_LEN_L    = 8'(MAX_LEN);
    localparam logic [2:0]  STEP_LAST    = 3'(STEPS_PER_COLOR - 1);

    logic [1:0]  state_r, state_nxt_s;
    logic [31:0] seed_r, seed_nxt_s;
    logic [7:0]  level_r, level_nxt_s;
    logic [7:0]  index_r, index_nxt_s;
    logic [2:0]  step_cnt_r, step_cnt_nxt_s;
    logic        is_last_s;

    assign is_last_s = (index_r == (level_r - 8'd1));

    // Next-state and datapath update; abort overrides every other request.
    always_comb begin
        state_nxt_s    = state_r;
        seed_nxt_s     = seed_r;
        level_nxt_s    = level_r;
        index_nxt_s    = index_r;
        step_cnt_nxt_s = step_cnt_r;
        if (abort) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // A zero seed would lock the LFSR, so substitute a known-good one.
                        seed_nxt_s  = (seed_in == 32'd0) ? DEFAULT_SEED : seed_in;
                        level_nxt_s = 8'd1;
                        index_nxt_s = 8'd0;
                    end else if (extend) begin
                        if (level_r < MAX_LEN_L) begin
                            level_nxt_s = level_r + 8'd1;
                        end else begin
                            level_nxt_s = level_r;
                        end
                    end else if (replay) begin
                        if (level_r != 8'd0) begin
                            index_nxt_s = 8'd0;
                            state_nxt_s = LOAD;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LOAD: begin
                    state_nxt_s = PRESENT;
                end
                PRESENT: begin
                    if (next) begin
                        if (is_last_s) begin
                            state_nxt_s = IDLE;
                        end else begin
                            index_nxt_s    = index_r + 8'd1;
                            step_cnt_nxt_s = 3'd0;
                            state_nxt_s    = STEP;
                        end
                    end else begin
                        state_nxt_s = PRESENT;
                    end
                end
                STEP: begin
                    step_cnt_nxt_s = step_cnt_r + 3'd1;
                    if (step_cnt_r == STEP_LAST) begin
                        state_nxt_s = PRESENT;
                    end else begin
                        state_nxt_s = STEP;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            seed_r     <= DEFAULT_SEED;
            level_r    <= 8'd0;
            index_r    <= 8'd0;
            step_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            seed_r     <= seed_nxt_s;
            level_r    <= level_nxt_s;
            index_r    <= index_nxt_s;
            step_cnt_r <= step_cnt_nxt_s;
        end
    end

    // Controls decode straight from the state so load and shift are mutually exclusive.
    assign lfsr_load       = (state_r == LOAD);
    assign lfsr_enable     = (state_r == STEP);
    assign lfsr_load_value = seed_r;
    assign color_valid     = (state_r == PRESENT);
    assign color           = color_valid ? lfsr_value[1:0] : 2'd0;
    assign last            = color_valid && is_last_s;
    assign done            = last && next && !abort && !rst;
    assign level           = level_r;
    assign full            = (level_r == MAX_LEN_L);
    assign busy            = (state_r != IDLE);

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Table-driven bench for simon_seq_ctrl paired with a 32-bit LFSR (taps 31,21,1,0),
// plus a MAX_LEN=4 instance for saturation.
module tb_simon_seq_ctrl;

    localparam logic [31:0] L0 = 32'h2048FAFA;
    localparam logic [31:0] S1 = 32'h00000001;

    logic        clk = 1'b0;
    logic        rst, start, extend, replay, next, abort;
    logic [31:0] seed_in;
    logic [31:0] lfsr_value;
    logic        lfsr_enable, lfsr_load, color_valid, last, done, full, busy;
    logic [31:0] lfsr_load_value;
    logic [1:0]  color;
    logic [7:0]  level;

    logic        start4, extend4, zero4;
    logic [31:0] seed4, zero32;
    logic        en4, ld4, cv4, last4, done4, full4, busy4;
    logic [31:0] lv4;
    logic [1:0]  color4;
    logic [7:0]  level4;

    int checks   = 0;
    int failures = 0;
    int row      = 0;

    typedef struct {
        logic        st;
        logic [31:0] sd;
        logic        ex, rp, nx, ab;
        logic        b, cv;
        logic [1:0]  col;
        logic        lst, dn, ld, en;
        logic [7:0]  lvl;
        logic [31:0] lval;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    simon_seq_ctrl #(.MAX_LEN(32), .STEPS_PER_COLOR(2)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in), .extend(extend),
        .replay(replay), .next(next), .abort(abort), .lfsr_value(lfsr_value),
        .lfsr_enable(lfsr_enable), .lfsr_load(lfsr_load), .lfsr_load_value(lfsr_load_value),
        .color(color), .color_valid(color_valid), .last(last), .done(done),
        .level(level), .full(full), .busy(busy)
    );

    simon_seq_ctrl #(.MAX_LEN(4), .STEPS_PER_COLOR(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .seed_in(seed4), .extend(extend4),
        .replay(zero4), .next(zero4), .abort(zero4), .lfsr_value(zero32),
        .lfsr_enable(en4), .lfsr_load(ld4), .lfsr_load_value(lv4),
        .color(color4), .color_valid(cv4), .last(last4), .done(done4),
        .level(level4), .full(full4), .busy(busy4)
    );

    // Team LFSR: shift left, feedback from taps 31,21,1,0 into bit 0; load wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_value <= 32'd0;
        end else if (lfsr_load) begin
            lfsr_value <= lfsr_load_value;
        end else if (lfsr_enable) begin
            lfsr_value <= {lfsr_value[30:0],
                           lfsr_value[31] ^ lfsr_value[21] ^ lfsr_value[1] ^ lfsr_value[0]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] sd, input logic ex,
                                input logic rp, input logic nx, input logic ab,
                                input logic b, input logic cv, input logic [1:0] col,
                                input logic lst, input logic dn, input logic ld,
                                input logic en, input logic [7:0] lvl,
                                input logic [31:0] lval);
        vec_t v;
        v.st = st; v.sd = sd; v.ex = ex; v.rp = rp; v.nx = nx; v.ab = ab;
        v.b = b; v.cv = cv; v.col = col; v.lst = lst; v.dn = dn; v.ld = ld;
        v.en = en; v.lvl = lvl; v.lval = lval;
        return v;
    endfunction

    task automatic check_all(input logic b, input logic cv, input logic [1:0] col,
                             input logic lst, input logic dn, input logic ld,
                             input logic en, input logic [7:0] lvl, input logic [31:0] lval);
        chk("busy", 32'(busy), 32'(b));
        chk("color_valid", 32'(color_valid), 32'(cv));
        chk("color", 32'(color), 32'(col));
        chk("last", 32'(last), 32'(lst));
        chk("done", 32'(done), 32'(dn));
        chk("lfsr_load", 32'(lfsr_load), 32'(ld));
        chk("lfsr_enable", 32'(lfsr_enable), 32'(en));
        chk("level", 32'(level), 32'(lvl));
        chk("lfsr_load_value", lfsr_load_value, lval);
    endtask

    initial begin
        //         st sd  ex rp nx ab | b cv col lst dn ld en lvl lval
        vecs.push_back(mk(1, S1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, L0)); // r0 start
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, S1));
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, S1));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1)); // replay
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 3, S1)); // LOAD
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1)); // hold
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1)); // STEP
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 3, S1)); // 0x6
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 2, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 3, 1, 0, 0, 0, 3, S1)); // 0x1B
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 3, 1, 1, 0, 0, 3, S1)); // done
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1)); // r16 replay
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 1, 3, S1)); // abort in STEP
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1)); // r22 replay
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 1, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 1, 2, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 2, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1, 3, S1));
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 3, 1, 1, 0, 0, 3, S1)); // same seq, done
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1)); // r34 replay
        vecs.push_back(mk(1, 5,   0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 3, S1)); // start in LOAD ignored
        vecs.push_back(mk(0, 0,   0, 0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 3, S1)); // abort beats next
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1));
        vecs.push_back(mk(1, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, S1)); // start+replay
        vecs.push_back(mk(0, 0,   0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, L0)); // seed 0 -> default
        vecs.push_back(mk(0, 0,   1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0, 1, L0)); // extend in LOAD ignored
        vecs.push_back(mk(0, 0,   0, 0, 1, 0,  1, 1, 2, 1, 1, 0, 0, 1, L0)); // single step
        vecs.push_back(mk(0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, L0));

        rst = 1'b1; start = 1'b0; extend = 1'b0; replay = 1'b0; next = 1'b0; abort = 1'b0;
        seed_in = 32'd0; start4 = 1'b0; extend4 = 1'b0; seed4 = 32'd0;
        zero4 = 1'b0; zero32 = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_all(0, 0, 0, 0, 0, 0, 0, 8'd0, L0);
        chk("reset full", 32'(full), 32'd0);
        rst = 1'b0;

        // Replay with level 0 must not start a load.
        @(negedge clk); replay = 1'b1;
        @(negedge clk); replay = 1'b0; #1;
        chk("replay lvl0 load", 32'(lfsr_load), 32'd0);
        chk("replay lvl0 busy", 32'(busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            row = i;
            start = vecs[i].st; seed_in = vecs[i].sd; extend = vecs[i].ex;
            replay = vecs[i].rp; next = vecs[i].nx; abort = vecs[i].ab;
            #1;
            check_all(vecs[i].b, vecs[i].cv, vecs[i].col, vecs[i].lst, vecs[i].dn,
                      vecs[i].ld, vecs[i].en, vecs[i].lvl, vecs[i].lval);
        end
        row = -1;

        // Reset while presenting.
        @(negedge clk);
        start = 1'b0; seed_in = 32'd0; extend = 1'b0; next = 1'b0; abort = 1'b0; replay = 1'b1;
        @(negedge clk); replay = 1'b0; #1;
        chk("rst test load", 32'(lfsr_load), 32'd1);
        @(negedge clk); #1;
        chk("rst test present", 32'(color_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check_all(0, 0, 0, 0, 0, 0, 0, 8'd0, L0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("post rst load", 32'(lfsr_load), 32'd0);
        chk("post rst enable", 32'(lfsr_enable), 32'd0);
        chk("post rst busy", 32'(busy), 32'd0);

        // Saturation at MAX_LEN = 4.
        @(negedge clk); start4 = 1'b1; seed4 = 32'h1234;
        @(negedge clk); start4 = 1'b0; extend4 = 1'b1; #1;
        chk("m4 level after start", 32'(level4), 32'd1);
        @(negedge clk); @(negedge clk); #1;
        chk("m4 level 3", 32'(level4), 32'd3);
        chk("m4 not full", 32'(full4), 32'd0);
        @(negedge clk); @(negedge clk); @(negedge clk); extend4 = 1'b0; #1;
        chk("m4 level sat", 32'(level4), 32'd4);
        chk("m4 full", 32'(full4), 32'd1);
        chk("m4 busy", 32'(busy4), 32'd0);
        chk("m4 seed", lv4, 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
